// File: rtl/f_pkg.sv
// Shared FP32 definitions for the multiplier sequencer and the classifier:
// result constants, the operand class record and the sequencer state encoding.
package f_pkg;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
    logic subnormal;
    logic normal;
    logic sign;
  } f_class_t;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ISSUE,
    WAIT,
    RESP
  } mul_seq_state_t;

  // Replace a subnormal with a zero of the same sign; anything else passes through.
  function automatic logic [31:0] flush_subnormal(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? {x[31], 31'h0} : x;
  endfunction

endpackage

// File: rtl/f_classify.sv
// Combinational FP32 operand classifier.
// Also intended for reuse by the add and div sequencers.
module f_classify
  import f_pkg::*;
(
  input  logic [31:0] x,
  output f_class_t    cls
);

  logic [7:0]  exp_f;
  logic [22:0] sig_f;
  logic        exp_max;
  logic        exp_min;
  logic        sig_zero;

  assign exp_f    = x[30:23];
  assign sig_f    = x[22:0];
  assign exp_max  = (exp_f == 8'hFF);
  assign exp_min  = (exp_f == 8'h00);
  assign sig_zero = (sig_f == 23'h0);

  always_comb begin
    cls           = '0;
    cls.nan       = exp_max & ~sig_zero;
    // A NaN with the quiet bit clear is signalling.
    cls.snan      = exp_max & ~sig_zero & ~sig_f[22];
    cls.inf       = exp_max & sig_zero;
    cls.zero      = exp_min & sig_zero;
    cls.subnormal = exp_min & ~sig_zero;
    cls.normal    = ~exp_max & ~exp_min;
    cls.sign      = x[31];
  end

endmodule

// File: rtl/f_mul_seq_ctrl.sv
// Sequencer in front of the multi-cycle FP32 multiplier core: resolves special
// operands locally, dispatches finite pairs to the core and guards it with a watchdog.
module f_mul_seq_ctrl
  import f_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter bit FTZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        core_start,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  // The abort is registered from the WAIT cycle holding this count, so the
  // watchdog reads TIMEOUT-1 once the response is presented.
  localparam logic [31:0] WD_LIMIT = (TIMEOUT >= 2) ? 32'(TIMEOUT - 2) : 32'd0;

  mul_seq_state_t  state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]     res_q, res_d;
  logic [2:0]      flags_q, flags_d;

  f_class_t cls_a;
  f_class_t cls_b;
  logic     prod_sign;
  logic     both_finite;

  f_classify u_cls_a (.x(a_q), .cls(cls_a));
  f_classify u_cls_b (.x(b_q), .cls(cls_b));

  assign prod_sign   = cls_a.sign ^ cls_b.sign;
  assign both_finite = (cls_a.normal | cls_a.subnormal) & (cls_b.normal | cls_b.subnormal);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = FTZ ? flush_subnormal(in_a) : in_a;
          b_d     = FTZ ? flush_subnormal(in_b) : in_b;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = RESP;
        if (cls_a.nan | cls_b.nan) begin
          res_d   = QNAN;
          flags_d = {cls_a.snan | cls_b.snan, 1'b1, 1'b0};
        end else if ((cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf)) begin
          res_d   = QNAN;
          flags_d = 3'b110;
        end else if (cls_a.inf | cls_b.inf) begin
          res_d   = POS_INF | {prod_sign, 31'h0};
          flags_d = 3'b010;
        end else if (cls_a.zero | cls_b.zero) begin
          res_d   = {prod_sign, 31'h0};
          flags_d = 3'b010;
        end else if (both_finite) begin
          state_d = ISSUE;
        end else begin
          res_d   = QNAN;
          flags_d = 3'b110;
        end
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A done pulse on the abort cycle still delivers the core's product.
        if (core_done) begin
          res_d   = core_result;
          flags_d = 3'b000;
          state_d = RESP;
        end else if (32'(wd_q) >= WD_LIMIT) begin
          res_d   = QNAN;
          flags_d = 3'b001;
          state_d = RESP;
        end
      end

      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign core_start = (state_q == ISSUE);
  assign out_valid  = (state_q == RESP);
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_f_mul_seq_ctrl.sv
// Self-checking bench for f_mul_seq_ctrl (TIMEOUT=8, FTZ=1): vector table with a
// result scoreboard, a behavioural core responder, plus reset-in-WAIT and stale-done sequences.
module tb_f_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  f_mul_seq_ctrl #(.TIMEOUT(8), .FTZ(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_done  (core_done),
    .core_result(core_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] core_res;
    int          delay;      // cycles from core_start to core_done; -1 = never
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
    int          exp_lat;
    int          exp_starts;
    int          hold;       // extra cycles out_ready stays low in RESP
    bit          late_done;  // pulse core_done in IDLE after the handoff
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } sb_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];
  sb_t  sb_q[$];
  int   tests;
  int   failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  starts;
    int  start_cyc;
    int  lat;
    bit  seen;
    sb_t exp_e;
    starts    = 0;
    start_cyc = -1;
    lat       = 0;
    seen      = 1'b0;
    exp_e     = '0;

    chk("in_ready_idle", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back('{res: v.exp_res, flags: v.exp_flags});

    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      core_done = 1'b0;
      if (core_start) begin
        starts++;
        start_cyc = cyc;
        chk("core_a", core_a, v.a);
        chk("core_b", core_b, v.b);
      end
      if (start_cyc > 0 && v.delay > 0 && cyc == start_cyc + v.delay) begin
        core_done   = 1'b1;
        core_result = v.core_res;
      end
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    core_done = 1'b0;

    chk("resp_seen", {31'h0, seen}, 32'd1);
    chk("latency", lat, v.exp_lat);
    chk("core_starts", starts, v.exp_starts);
    if (seen && sb_q.size() > 0) begin
      exp_e = sb_q.pop_front();
      chk("out_result", out_result, exp_e.res);
      chk("out_flags", {29'h0, out_flags}, {29'h0, exp_e.flags});
    end

    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
      chk("hold_result", out_result, v.exp_res);
      chk("hold_flags", {29'h0, out_flags}, {29'h0, v.exp_flags});
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", {31'h0, out_valid}, 32'd0);
    chk("ready_back", {31'h0, in_ready}, 32'd1);

    if (v.late_done) begin
      core_done   = 1'b1;
      core_result = 32'hDEADBEEF;
      @(posedge clk); #1;
      core_done = 1'b0;
      chk("late_done_ready", {31'h0, in_ready}, 32'd1);
      chk("late_done_valid", {31'h0, out_valid}, 32'd0);
    end

    $display("[TB] txn %0d a=%h b=%h result=%h flags=%b lat=%0d starts=%0d",
             idx, v.a, v.b, out_result, out_flags, lat, starts);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    tests       = 0;
    failed      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    core_done   = 1'b0;
    core_result = '0;
    out_ready   = 1'b0;

    //        a             b             core_res      dly  exp_res       flg     lat starts hold late
    vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000,  4, 32'h40000000, 3'b000,  7, 1, 0, 1'b0};
    vecs[1]  = '{32'h7F800000, 32'h80000000, 32'h0,        -1, 32'h7FC00000, 3'b110,  2, 0, 0, 1'b0};
    vecs[2]  = '{32'hFF800000, 32'h40000000, 32'h0,        -1, 32'hFF800000, 3'b010,  2, 0, 0, 1'b0};
    vecs[3]  = '{32'h7FA00000, 32'h3F800000, 32'h0,        -1, 32'h7FC00000, 3'b110,  2, 0, 0, 1'b0};
    vecs[4]  = '{32'h00000001, 32'hBF800000, 32'h0,        -1, 32'h80000000, 3'b010,  2, 0, 0, 1'b0};
    vecs[5]  = '{32'h40400000, 32'hC0000000, 32'hC0C00000,  1, 32'hC0C00000, 3'b000,  4, 1, 5, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h3F800000, 32'h0,        -1, 32'h7FC00000, 3'b001, 10, 1, 0, 1'b1};
    vecs[7]  = '{32'h40000000, 32'h40000000, 32'h40800000,  7, 32'h40800000, 3'b000, 10, 1, 0, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h40A00000, 32'h0,        -1, 32'h80000000, 3'b010,  2, 0, 0, 1'b0};
    vecs[9]  = '{32'h7FC00000, 32'h00000000, 32'h0,        -1, 32'h7FC00000, 3'b010,  2, 0, 0, 1'b0};
    vecs[10] = '{32'hFFC00000, 32'h7F800000, 32'h0,        -1, 32'h7FC00000, 3'b010,  2, 0, 0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h80000000, 32'h0,        -1, 32'h00000000, 3'b010,  2, 0, 0, 1'b0};
    vecs[12] = '{32'h7F800000, 32'hBF800000, 32'h0,        -1, 32'hFF800000, 3'b010,  2, 0, 0, 1'b0};
    vecs[13] = '{32'h00000000, 32'hFF800000, 32'h0,        -1, 32'h7FC00000, 3'b110,  2, 0, 0, 1'b0};
    vecs[14] = '{32'h807FFFFF, 32'h807FFFFF, 32'h0,        -1, 32'h00000000, 3'b010,  2, 0, 0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_core_start", {31'h0, core_start}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", {29'h0, out_flags}, 32'h0);
    chk("rst_core_a", core_a, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while the core operation is outstanding.
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_in_ready", {31'h0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("wrst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("wrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("wrst_core_start", {31'h0, core_start}, 32'd0);
    chk("wrst_out_result", out_result, 32'h0);
    chk("wrst_out_flags", {29'h0, out_flags}, 32'h0);
    chk("wrst_core_a", core_a, 32'h0);
    chk("wrst_core_b", core_b, 32'h0);

    // The abandoned operation's done pulse arrives after reset.
    core_done   = 1'b1;
    core_result = 32'h12345678;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("stale_in_ready", {31'h0, in_ready}, 32'd1);
    chk("stale_out_valid", {31'h0, out_valid}, 32'd0);
    chk("stale_out_result", out_result, 32'h0);
    $display("[TB] txn reset-in-WAIT and stale core_done sequence done");

    run_vec(vecs[0], NVEC);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
